// File: rtl/aqed_pkg.sv
// Shared types and default widths for the A-QED response-side checker.
package aqed_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int SEQ_W_DEF   = 17;
  localparam int BOUND_W_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ORIG = 2'd1,
    ST_WAIT_DUP  = 2'd2,
    ST_DONE      = 2'd3
  } chk_state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_LATE   = 2'd1,
    ERR_ORDER  = 2'd2,
    ERR_DOUBLE = 2'd3
  } err_code_t;

endpackage

// File: rtl/aqed_seq_capture.sv
// Sequence-index capture cell: holds one sampled index with its valid flag and
// captures the output word whose index matches (live index bypass on the issue cycle).
module aqed_seq_capture
  import aqed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEQ_W  = SEQ_W_DEF
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              issue_i,
  input  logic [SEQ_W-1:0]  seq_i,
  input  logic              arm_i,
  input  logic              acc_v_i,
  input  logic [SEQ_W-1:0]  acc_idx_i,
  input  logic [DATA_W-1:0] acc_dat_i,
  output logic              vld_o,
  output logic [SEQ_W-1:0]  seq_eff_o,
  output logic              double_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] word_d_o
);

  logic              vld_q, vld_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] word_q, word_d;

  // Until the index is registered, compare against the live issue index.
  assign seq_eff_o = vld_q ? seq_q : seq_i;
  assign double_o  = issue_i & vld_q;
  assign hit_o     = arm_i & acc_v_i & (vld_q | issue_i) & (acc_idx_i == seq_eff_o);

  always_comb begin
    vld_d  = vld_q;
    seq_d  = seq_q;
    word_d = word_q;
    if (issue_i && !vld_q) begin
      vld_d = 1'b1;
      seq_d = seq_i;
    end else begin
      vld_d = vld_q;
    end
    if (hit_o) begin
      word_d = acc_dat_i;
    end else begin
      word_d = word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      vld_q  <= 1'b0;
      seq_q  <= '0;
      word_q <= '0;
    end else if (en_i) begin
      vld_q  <= vld_d;
      seq_q  <= seq_d;
      word_q <= word_d;
    end
  end

  assign vld_o    = vld_q;
  assign word_d_o = word_d;

endmodule

// File: rtl/aqed_out_checker.sv
// A-QED response checker: captures the original and duplicate outputs of memory_core
// and reports qed_done/qed_check. Define AQED_BOUND_CHECK_EN to add the response watchdog.
module aqed_out_checker
  import aqed_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEQ_W   = SEQ_W_DEF,
  parameter int BOUND_W = BOUND_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  input  logic [DATA_W-1:0]  acc_out_dat,
  input  logic               acc_out_v,
  input  logic               orig_issued,
  input  logic [SEQ_W-1:0]   orig_seq,
  input  logic               dup_issued,
  input  logic [SEQ_W-1:0]   dup_seq,
`ifdef AQED_BOUND_CHECK_EN
  input  logic [BOUND_W-1:0] resp_bound,
  output logic               bound_err,
`endif
  output logic [SEQ_W-1:0]   out_count,
  output logic               orig_done,
  output logic               qed_done,
  output logic               qed_check,
  output logic               idx_err,
  output err_code_t          err_code
);

  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  chk_state_t        state_q, state_d;
  logic [SEQ_W-1:0]  out_count_q, out_count_d;
  logic              orig_done_q, orig_done_d;
  logic              qed_done_q, qed_done_d;
  logic              qed_check_q, qed_check_d;
  logic              idx_err_q, idx_err_d;
  err_code_t         err_code_q, err_code_d;

  logic              clr_s, accept_s, oi_s, di_s;
  logic              o_vld_s, o_dbl_s, o_hit_s, o_arm_s;
  logic              d_vld_s, d_dbl_s, d_hit_s, d_arm_s;
  logic [SEQ_W-1:0]  o_seq_s, d_seq_s;
  logic [DATA_W-1:0] o_word_s, d_word_s;
  logic              late_s, order_s;

  assign clr_s    = reset | (flush & clk_en);
  assign accept_s = clk_en & acc_out_v;
  // Issue pulses are ignored once the check has concluded.
  assign oi_s     = clk_en & orig_issued & (state_q != ST_DONE);
  assign di_s     = clk_en & dup_issued & (state_q != ST_DONE);
  assign o_arm_s  = (state_q == ST_IDLE) | (state_q == ST_WAIT_ORIG);
  assign d_arm_s  = (state_q == ST_WAIT_DUP);

  aqed_seq_capture #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_orig (
    .clk(clk), .clr_i(clr_s), .en_i(clk_en), .issue_i(oi_s), .seq_i(orig_seq),
    .arm_i(o_arm_s), .acc_v_i(accept_s), .acc_idx_i(out_count_q), .acc_dat_i(acc_out_dat),
    .vld_o(o_vld_s), .seq_eff_o(o_seq_s), .double_o(o_dbl_s), .hit_o(o_hit_s),
    .word_d_o(o_word_s)
  );

  aqed_seq_capture #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_dup (
    .clk(clk), .clr_i(clr_s), .en_i(clk_en), .issue_i(di_s), .seq_i(dup_seq),
    .arm_i(d_arm_s), .acc_v_i(accept_s), .acc_idx_i(out_count_q), .acc_dat_i(acc_out_dat),
    .vld_o(d_vld_s), .seq_eff_o(d_seq_s), .double_o(d_dbl_s), .hit_o(d_hit_s),
    .word_d_o(d_word_s)
  );

  // An index already passed by the output counter can never be observed.
  assign late_s  = (oi_s & ~o_vld_s & (o_seq_s < out_count_q)) |
                   (di_s & ~d_vld_s & (d_seq_s < out_count_q));
  assign order_s = di_s & ~d_vld_s & ((state_q == ST_IDLE) | (d_seq_s <= o_seq_s));

  always_comb begin
    state_d     = state_q;
    out_count_d = out_count_q;
    orig_done_d = orig_done_q;
    qed_done_d  = qed_done_q;
    qed_check_d = qed_check_q;
    idx_err_d   = idx_err_q;
    err_code_d  = err_code_q;
    if (accept_s && (out_count_q != '1)) begin
      out_count_d = out_count_q + SEQ_ONE;
    end else begin
      out_count_d = out_count_q;
    end
    if (o_dbl_s || d_dbl_s) begin
      idx_err_d  = 1'b1;
      err_code_d = ERR_DOUBLE;
    end else begin
      idx_err_d  = idx_err_q;
    end
    if (late_s || order_s) begin
      state_d     = ST_DONE;
      qed_done_d  = 1'b1;
      qed_check_d = 1'b0;
      idx_err_d   = 1'b1;
      err_code_d  = late_s ? ERR_LATE : ERR_ORDER;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (oi_s) begin
            state_d     = o_hit_s ? ST_WAIT_DUP : ST_WAIT_ORIG;
            orig_done_d = o_hit_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_ORIG: begin
          if (o_hit_s) begin
            state_d     = ST_WAIT_DUP;
            orig_done_d = 1'b1;
          end else begin
            state_d = ST_WAIT_ORIG;
          end
        end
        ST_WAIT_DUP: begin
          if (d_hit_s) begin
            state_d     = ST_DONE;
            qed_done_d  = 1'b1;
            qed_check_d = (o_word_s == d_word_s);
          end else begin
            state_d = ST_WAIT_DUP;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_s) begin
      state_q     <= ST_IDLE;
      out_count_q <= '0;
      orig_done_q <= 1'b0;
      qed_done_q  <= 1'b0;
      qed_check_q <= 1'b0;
      idx_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else if (clk_en) begin
      state_q     <= state_d;
      out_count_q <= out_count_d;
      orig_done_q <= orig_done_d;
      qed_done_q  <= qed_done_d;
      qed_check_q <= qed_check_d;
      idx_err_q   <= idx_err_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef AQED_BOUND_CHECK_EN
  localparam logic [BOUND_W-1:0] BOUND_ONE = BOUND_W'(1);
  logic [BOUND_W-1:0] wd_q, wd_d;
  logic               bound_err_q, bound_err_d;

  // Watchdog counts WAIT_ORIG cycles; it only flags, never steers the FSM.
  always_comb begin
    wd_d        = wd_q;
    bound_err_d = bound_err_q;
    if ((state_q == ST_IDLE) && oi_s) begin
      wd_d = '0;
    end else if (state_q == ST_WAIT_ORIG) begin
      wd_d = (wd_q == '1) ? wd_q : wd_q + BOUND_ONE;
      if ((wd_d == resp_bound) && !o_hit_s) begin
        bound_err_d = 1'b1;
      end else begin
        bound_err_d = bound_err_q;
      end
    end else begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_s) begin
      wd_q        <= '0;
      bound_err_q <= 1'b0;
    end else if (clk_en) begin
      wd_q        <= wd_d;
      bound_err_q <= bound_err_d;
    end
  end

  assign bound_err = bound_err_q;
`endif

  assign out_count = out_count_q;
  assign orig_done = orig_done_q;
  assign qed_done  = qed_done_q;
  assign qed_check = qed_check_q;
  assign idx_err   = idx_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_aqed_out_checker.sv
// Bench for aqed_out_checker: directed scenarios plus randomized traffic checked
// cycle by cycle against a rule-level reference model.
module tb_aqed_out_checker;
  import aqed_pkg::*;

  localparam int DW = 16;
  localparam int SW = 17;
  localparam int BW = 17;

  logic          clk = 1'b0;
  logic          reset, clk_en, flush;
  logic [DW-1:0] acc_out_dat;
  logic          acc_out_v, orig_issued, dup_issued;
  logic [SW-1:0] orig_seq, dup_seq;
  logic [SW-1:0] out_count;
  logic          orig_done, qed_done, qed_check, idx_err;
  err_code_t     err_code;
`ifdef AQED_BOUND_CHECK_EN
  logic [BW-1:0] resp_bound;
  logic          bound_err;
`endif

  always #5 clk = ~clk;

  aqed_out_checker #(.DATA_W(DW), .SEQ_W(SW), .BOUND_W(BW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .acc_out_dat(acc_out_dat), .acc_out_v(acc_out_v),
    .orig_issued(orig_issued), .orig_seq(orig_seq),
    .dup_issued(dup_issued), .dup_seq(dup_seq),
`ifdef AQED_BOUND_CHECK_EN
    .resp_bound(resp_bound), .bound_err(bound_err),
`endif
    .out_count(out_count), .orig_done(orig_done), .qed_done(qed_done),
    .qed_check(qed_check), .idx_err(idx_err), .err_code(err_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which indices were announced, which words seen, and the verdict.
  int m_cnt, m_oseq, m_dseq, m_oword, m_wd;
  bit m_ov, m_dv, m_owv, m_done, m_chk, m_err, m_berr;

  task automatic model_reset();
    m_cnt = 0; m_oseq = 0; m_dseq = 0; m_oword = 0; m_wd = 0;
    m_ov = 0; m_dv = 0; m_owv = 0; m_done = 0; m_chk = 0; m_err = 0; m_berr = 0;
  endtask

  task automatic model_step();
    bit idle, wait_orig, fatal, new_o, new_d, ohit;
    int oseq, dseq, idx;
    if (reset || (flush && clk_en)) begin
      model_reset();
      return;
    end
    if (!clk_en) return;
    idx = m_cnt;
    if (!m_done) begin
      idle = !m_ov;
      wait_orig = m_ov && !m_owv;
      fatal = 0; new_o = 0; new_d = 0;
      oseq = m_oseq; dseq = m_dseq;
      if (orig_issued) begin
        if (m_ov) m_err = 1;
        else if (int'(orig_seq) < m_cnt) fatal = 1;
        else begin new_o = 1; oseq = int'(orig_seq); end
      end
      if (dup_issued) begin
        if (m_dv) m_err = 1;
        else if (idle || int'(dup_seq) < m_cnt || int'(dup_seq) <= m_oseq) fatal = 1;
        else begin new_d = 1; dseq = int'(dup_seq); end
      end
      ohit = (m_ov || new_o) && !m_owv && acc_out_v && (idx == oseq);
`ifdef AQED_BOUND_CHECK_EN
      if (new_o) m_wd = 0;
      if (wait_orig) begin
        if (m_wd < (1 << BW) - 1) m_wd++;
        if (m_wd == int'(resp_bound) && !ohit) m_berr = 1;
      end
`endif
      if (fatal) begin
        m_done = 1; m_chk = 0; m_err = 1;
      end else if (ohit) begin
        m_owv = 1; m_oword = int'(acc_out_dat);
      end else if (m_owv && (m_dv || new_d) && acc_out_v && (idx == dseq)) begin
        m_done = 1; m_chk = (m_oword == int'(acc_out_dat));
      end
      m_ov = m_ov | new_o; m_dv = m_dv | new_d;
      m_oseq = oseq; m_dseq = dseq;
      if (wait_orig) begin end
    end
    if (acc_out_v && m_cnt != (1 << SW) - 1) m_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    check_eq("out_count", 32'(out_count), 32'(m_cnt));
    check_eq("orig_done", 32'(orig_done), 32'(m_owv));
    check_eq("qed_done", 32'(qed_done), 32'(m_done));
    check_eq("qed_check", 32'(qed_check), 32'(m_chk));
    check_eq("idx_err", 32'(idx_err), 32'(m_err));
`ifdef AQED_BOUND_CHECK_EN
    check_eq("bound_err", 32'(bound_err), 32'(m_berr));
`endif
  endtask

  task automatic drv(input bit v, input int d, input bit oi, input int os, input bit di, input int ds);
    acc_out_v = v; acc_out_dat = DW'(d);
    orig_issued = oi; orig_seq = SW'(os);
    dup_issued = di; dup_seq = SW'(ds);
    step();
    acc_out_v = 0; orig_issued = 0; dup_issued = 0;
  endtask

  task automatic do_reset();
    reset = 1; clk_en = 1;
    step();
    reset = 0;
  endtask

  task automatic run_s1(input int w7, input bit exp_chk, input string tag);
    do_reset();
    drv(0, 0, 1, 3, 0, 0);
    drv(0, 0, 0, 0, 1, 7);
    for (int i = 0; i < 10; i++) begin
      drv(1, (i == 7) ? w7 : 16'h0010 + i, 0, 0, 0, 0);
      if (i == 2) check_eq({tag, "_orig_done_early"}, 32'(orig_done), 32'd0);
      if (i == 3) check_eq({tag, "_orig_done"}, 32'(orig_done), 32'd1);
      if (i == 6) check_eq({tag, "_qed_done_early"}, 32'(qed_done), 32'd0);
      if (i == 7) begin
        check_eq({tag, "_qed_done"}, 32'(qed_done), 32'd1);
        check_eq({tag, "_qed_check"}, 32'(qed_check), 32'(exp_chk));
        check_eq({tag, "_idx_err"}, 32'(idx_err), 32'd0);
      end
    end
    check_eq({tag, "_out_count"}, 32'(out_count), 32'd10);
  endtask

  int to, td, os, ds;

  initial begin
    reset = 1; clk_en = 1; flush = 0;
    acc_out_v = 0; acc_out_dat = '0; orig_issued = 0; dup_issued = 0;
    orig_seq = '0; dup_seq = '0;
`ifdef AQED_BOUND_CHECK_EN
    resp_bound = BW'(100);
`endif
    model_reset();

    do_reset();
    check_eq("rst_out_count", 32'(out_count), 32'd0);
    check_eq("rst_qed_done", 32'(qed_done), 32'd0);

    run_s1(16'h0013, 1'b1, "s1");
    run_s1(16'h0017, 1'b0, "s2");

    // Late original issue.
    do_reset();
    for (int i = 0; i < 4; i++) drv(1, 16'h0020 + i, 0, 0, 0, 0);
    drv(0, 0, 1, 2, 0, 0);
    check_eq("s3_idx_err", 32'(idx_err), 32'd1);
    check_eq("s3_qed_done", 32'(qed_done), 32'd1);
    check_eq("s3_qed_check", 32'(qed_check), 32'd0);

    // Same-cycle bypass for the original, then a matching duplicate.
    do_reset();
    for (int i = 0; i < 5; i++) drv(1, 16'h0030 + i, 0, 0, 0, 0);
    drv(1, 16'h00AB, 1, 5, 0, 0);
    check_eq("s4_orig_done", 32'(orig_done), 32'd1);
    drv(1, 16'h00AB, 0, 0, 1, 6);
    check_eq("s4_qed_check", 32'(qed_check), 32'd1);

    // Reset while waiting for the duplicate, then rerun scenario 1.
    do_reset();
    drv(0, 0, 1, 3, 0, 0);
    drv(0, 0, 0, 0, 1, 7);
    for (int i = 0; i < 5; i++) drv(1, 16'h0010 + i, 0, 0, 0, 0);
    check_eq("s5_mid_orig_done", 32'(orig_done), 32'd1);
    do_reset();
    check_eq("s5_rst_out_count", 32'(out_count), 32'd0);
    check_eq("s5_rst_orig_done", 32'(orig_done), 32'd0);
    check_eq("s5_rst_idx_err", 32'(idx_err), 32'd0);
    run_s1(16'h0013, 1'b1, "s5");

`ifdef AQED_BOUND_CHECK_EN
    resp_bound = BW'(4);
    do_reset();
    drv(0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drv(1, 16'h0040 + i, 0, 0, (i == 0) ? 1'b1 : 1'b0, 7);
      if (i == 2) check_eq("s6_bound_early", 32'(bound_err), 32'd0);
      if (i == 3) check_eq("s6_bound_err", 32'(bound_err), 32'd1);
    end
    drv(1, 16'h0046, 0, 0, 0, 0);
    drv(1, 16'h0045, 0, 0, 0, 0);
    check_eq("s6_qed_done", 32'(qed_done), 32'd1);
    check_eq("s6_qed_check", 32'(qed_check), 32'd1);
`endif

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
`ifdef AQED_BOUND_CHECK_EN
      resp_bound = BW'($urandom_range(1, 10));
`endif
      if ($urandom_range(0, 1) == 0) do_reset();
      else begin
        flush = 1; clk_en = 1;
        step();
        flush = 0;
      end
      to = $urandom_range(0, 5);
      td = to + $urandom_range(0, 6);
      os = 0;
      for (int c = 0; c < 32; c++) begin
        clk_en = ($urandom_range(0, 9) != 0);
        acc_out_v = ($urandom_range(0, 2) != 0);
        acc_out_dat = DW'(16'h0010 + $urandom_range(0, 3));
        orig_issued = (c == to) || ($urandom_range(0, 39) == 0);
        if (orig_issued) begin
          os = m_cnt + $urandom_range(0, 4);
          if ($urandom_range(0, 7) == 0) os = os - 3;
          if (os < 0) os = 0;
          orig_seq = SW'(os);
        end
        dup_issued = (c == td) || ($urandom_range(0, 39) == 0);
        if (dup_issued) begin
          ds = os + $urandom_range(1, 5);
          if ($urandom_range(0, 7) == 0) ds = ds - 4;
          if (ds < 0) ds = 0;
          dup_seq = SW'(ds);
        end
        flush = ($urandom_range(0, 59) == 0);
        step();
        orig_issued = 0; dup_issued = 0; acc_out_v = 0; flush = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
